param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 26 ++
 rtl/param_sync_fifo.sv | 145 ++++++++++++++
 tb/tb_param_sync_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the
// parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AE_THRESH  = 2;
    localparam int DEF_FWFT       = 0;

    // Occupancy runs 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One extra MSB tells full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write,
// asynchronous read, no reset on contents.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with flags,
// sticky errors and registered or FWFT read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = DEF_AE_THRESH,
    parameter int FWFT       = DEF_FWFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     r_en,
    input  logic                     clr_err,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     out_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] AF_T = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_T = CW'(AE_THRESH);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_set;
    logic                  unf_set;
    logic [DATA_WIDTH-1:0] head;

    // Flags come straight off the registered state.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign almost_full  = (cnt_q >= AF_T);
    assign almost_empty = (cnt_q <= AE_T);
    assign count        = cnt_q;

    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    assign ovf_set = w_en && full && !rd_acc;
    assign unf_set = r_en && empty;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && rst_n),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + C_ONE;
            2'b01:   cnt_d = cnt_q - C_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            cnt_q <= cnt_d;
        end
    end

    // A new error event beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out  = head;
            assign out_valid = !empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  vld_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    if (rd_acc) begin
                        dout_q <= head;
                    end
                    vld_q <= rd_acc;
                end
            end

            assign data_out  = dout_q;
            assign out_valid = vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for
// param_sync_fifo (registered and FWFT ports).
module tb_param_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       w_en;
    logic [7:0] data_in;
    logic       r_en;
    logic       clr_err;
    logic [7:0] data_out;
    logic       out_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic       f_w_en;
    logic [7:0] f_din;
    logic       f_r_en;
    logic [7:0] f_dout;
    logic       f_vld;
    logic       f_full;
    logic       f_empty;
    logic       f_af;
    logic       f_ae;
    logic [4:0] f_count;
    logic       f_ovf;
    logic       f_unf;

    int n_chk;
    int n_err;

    param_sync_fifo u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    param_sync_fifo #(.FWFT(1)) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_en         (f_w_en),
        .data_in      (f_din),
        .r_en         (f_r_en),
        .clr_err      (1'b0),
        .data_out     (f_dout),
        .out_valid    (f_vld),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .count        (f_count),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 16; i++) begin
            w_en    = 1'b1;
            data_in = 8'(base + i);
            step();
        end
        w_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_ae"}, int'(almost_empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_dout"}, int'(data_out), 0);
        chk({tag, "_vld"}, int'(out_valid), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_unf"}, int'(underflow), 0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
        data_in = 8'h00;
        f_w_en  = 1'b0;
        f_r_en  = 1'b0;
        f_din   = 8'h00;
        step();
        step();
        chk_reset_state("rst");
        rst_n = 1'b1;
        step();
        chk_reset_state("idle");

        // Fill 0x00..0x0F, then drain in order.
        for (int i = 0; i < 16; i++) begin
            w_en    = 1'b1;
            data_in = 8'(i);
            step();
            chk("fill_cnt", int'(count), i + 1);
            chk("fill_af", int'(almost_full), (i + 1 >= 14) ? 1 : 0);
            chk("fill_ae", int'(almost_empty), (i + 1 <= 2) ? 1 : 0);
        end
        w_en = 1'b0;
        chk("fill_full", int'(full), 1);
        chk("fill_empty", int'(empty), 0);
        for (int i = 0; i < 16; i++) begin
            r_en = 1'b1;
            step();
            chk("drain_vld", int'(out_valid), 1);
            chk("drain_data", int'(data_out), i);
            chk("drain_cnt", int'(count), 15 - i);
        end
        r_en = 1'b0;
        step();
        chk("drain_vld_end", int'(out_valid), 0);
        chk("drain_hold", int'(data_out), 8'h0F);
        chk("drain_empty", int'(empty), 1);

        // Write + read while full.
        fill(8'h10);
        chk("wf_full", int'(full), 1);
        w_en    = 1'b1;
        r_en    = 1'b1;
        data_in = 8'hAA;
        step();
        w_en = 1'b0;
        chk("wf_cnt", int'(count), 16);
        chk("wf_full2", int'(full), 1);
        chk("wf_pop", int'(data_out), 8'h10);
        chk("wf_ovf", int'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("wf_data", int'(data_out), (i < 15) ? 8'h11 + i : 8'hAA);
        end
        r_en = 1'b0;
        step();
        chk("wf_empty", int'(empty), 1);

        // Write + read while empty.
        w_en    = 1'b1;
        r_en    = 1'b1;
        data_in = 8'h33;
        step();
        w_en = 1'b0;
        r_en = 1'b0;
        chk("we_unf", int'(underflow), 1);
        chk("we_cnt", int'(count), 1);
        chk("we_vld", int'(out_valid), 0);
        chk("we_dout", int'(data_out), 8'hAA);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("we_clr", int'(underflow), 0);
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        chk("we_data", int'(data_out), 8'h33);
        chk("we_empty", int'(empty), 1);

        // Error event beats a coinciding clear.
        r_en = 1'b1;
        step();
        chk("pri_set", int'(underflow), 1);
        clr_err = 1'b1;
        step();
        chk("pri_keep", int'(underflow), 1);
        r_en = 1'b0;
        step();
        clr_err = 1'b0;
        chk("pri_clr", int'(underflow), 0);
        chk("pri_cnt", int'(count), 0);

        // Overflow, contents kept, then reset.
        fill(8'h40);
        w_en    = 1'b1;
        data_in = 8'hEE;
        step();
        w_en = 1'b0;
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_cnt", int'(count), 16);
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        chk("ovf_head", int'(data_out), 8'h40);
        chk("ovf_sticky", int'(overflow), 1);
        for (int i = 0; i < 15; i++) begin
            r_en = 1'b1;
            step();
            chk("ovf_data", int'(data_out), 8'h41 + i);
        end
        r_en = 1'b0;
        fill(8'h60);
        rst_n = 1'b0;
        w_en  = 1'b1;
        r_en  = 1'b1;
        step();
        rst_n = 1'b1;
        w_en  = 1'b0;
        r_en  = 1'b0;
        chk_reset_state("rst2");
        step();
        chk("rst2_cnt", int'(count), 0);

        // Alternating traffic across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            w_en    = 1'b1;
            data_in = 8'(i * 7 + 3);
            step();
            w_en = 1'b0;
            chk("alt_cnt_w", int'(count), 1);
            r_en = 1'b1;
            step();
            r_en = 1'b0;
            chk("alt_data", int'(data_out), (i * 7 + 3) % 256);
            chk("alt_cnt_r", int'(count), 0);
        end

        // First-word-fall-through instance.
        chk("fw_rst_vld", int'(f_vld), 0);
        chk("fw_rst_empty", int'(f_empty), 1);
        f_w_en = 1'b1;
        f_din  = 8'h5C;
        step();
        f_w_en = 1'b0;
        chk("fw_vld", int'(f_vld), 1);
        chk("fw_data", int'(f_dout), 8'h5C);
        chk("fw_cnt", int'(f_count), 1);
        f_r_en = 1'b1;
        step();
        f_r_en = 1'b0;
        chk("fw_empty", int'(f_empty), 1);
        chk("fw_vld_end", int'(f_vld), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
